// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Rotation and one-hot conversion live here so the top stays focused on the FSM.
package arb_pkg;

    localparam int NREQ = 4;

    typedef logic [NREQ-1:0] req_vec_t;
    typedef logic [1:0]      idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Rotate right so that bit n of the input lands at bit 0.
    function automatic req_vec_t rotr(input req_vec_t v, input idx_t n);
        logic [2*NREQ-1:0] w_dbl;
        w_dbl = {v, v} >> n;
        return w_dbl[NREQ-1:0];
    endfunction

    function automatic req_vec_t idx_to_onehot(input idx_t idx);
        req_vec_t w_oh;
        w_oh      = '0;
        w_oh[idx] = 1'b1;
        return w_oh;
    endfunction

endpackage

// File: rtl/rr_arbiter4_prio.sv
// Fixed-priority encoder over a 4-bit vector, LSB highest priority.
// The caller rotates the vector first, which turns it into round-robin.
module prio_enc4_casez
    import arb_pkg::*;
(
    input  req_vec_t vec,
    output idx_t     idx,
    output logic     valid
);

    always_comb begin
        idx   = 2'd0;
        valid = 1'b1;
        casez (vec)
            4'b???1: idx = 2'd0;
            4'b??10: idx = 2'd1;
            4'b?100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with registered one-hot grant,
// zero-bubble handover and a bounded hold time under contention.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       busy
);

    localparam int              HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
    localparam logic [HW-1:0]   HOLD_ONE = HW'(1);

    arb_state_t    r_state;
    idx_t          r_ptr;
    logic [HW-1:0] r_hold;
    req_vec_t      r_gnt;
    idx_t          r_gnt_id;

    arb_state_t    w_state_next;
    idx_t          w_ptr_next;
    logic [HW-1:0] w_hold_next;
    req_vec_t      w_gnt_next;
    idx_t          w_gnt_id_next;

    logic          w_owner_req;
    logic          w_others;
    logic          w_release;
    logic          w_force;
    idx_t          w_arb_ptr;
    req_vec_t      w_mask;
    req_vec_t      w_rot;
    idx_t          w_enc_idx;
    logic          w_enc_valid;
    idx_t          w_winner;

    assign w_owner_req = req[r_gnt_id];
    assign w_others    = |(req & ~r_gnt);
    assign w_release   = (r_state == OWNED) && !w_owner_req;
    assign w_force     = (r_state == OWNED) && w_owner_req && (r_hold == HOLD_MAX) && w_others;

    // On release or forced rotation the arbitration already uses the advanced pointer,
    // so the new winner is chosen under the updated priority in the same edge.
    assign w_arb_ptr = (w_release || w_force) ? idx_t'(r_gnt_id + 2'd1) : r_ptr;
    assign w_mask    = w_force ? ~r_gnt : '1;
    assign w_rot     = rotr(req & w_mask, w_arb_ptr);
    assign w_winner  = w_enc_idx + w_arb_ptr;

    prio_enc4_casez u_enc (
        .vec   (w_rot),
        .idx   (w_enc_idx),
        .valid (w_enc_valid)
    );

    always_comb begin
        w_state_next  = r_state;
        w_ptr_next    = r_ptr;
        w_hold_next   = r_hold;
        w_gnt_next    = r_gnt;
        w_gnt_id_next = r_gnt_id;
        case (r_state)
            IDLE: begin
                if (w_enc_valid) begin
                    w_state_next  = OWNED;
                    w_gnt_next    = idx_to_onehot(w_winner);
                    w_gnt_id_next = w_winner;
                    w_hold_next   = HOLD_ONE;
                end
            end
            OWNED: begin
                if (w_release || w_force) begin
                    w_ptr_next = w_arb_ptr;
                    if (w_enc_valid) begin
                        w_gnt_next    = idx_to_onehot(w_winner);
                        w_gnt_id_next = w_winner;
                        w_hold_next   = HOLD_ONE;
                    end else begin
                        w_state_next  = IDLE;
                        w_gnt_next    = '0;
                        w_gnt_id_next = '0;
                        w_hold_next   = '0;
                    end
                end else if (r_hold < HOLD_MAX) begin
                    w_hold_next = r_hold + HOLD_ONE;
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_gnt_next    = '0;
                w_gnt_id_next = '0;
                w_hold_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_gnt_id <= '0;
        end else begin
            r_state  <= w_state_next;
            r_ptr    <= w_ptr_next;
            r_hold   <= w_hold_next;
            r_gnt    <= w_gnt_next;
            r_gnt_id <= w_gnt_id_next;
        end
    end

    assign gnt    = r_gnt;
    assign gnt_id = r_gnt_id;
    assign busy   = |r_gnt;

endmodule

// File: doc/rr_arbiter4.md
# rr_arbiter4

Four-requester round-robin arbiter that shares one downstream resource, such as a decoder or bus port, among four masters. A combinational casez priority encoder runs on a request vector rotated by a last-winner pointer. A small state machine registers a one-hot grant, holds it while the winner keeps requesting, and forces rotation after a bounded hold time when other masters are waiting.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a master may hold the grant while any other request is pending. Legal range ≥ 2.
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per master; level-sensitive, held high until the master is done.
- `gnt`  output  4  registered one-hot grant; all-zero when idle.
- `gnt_id`  output  2  binary index of the granted master; 0 when idle.
- `busy`  output  1  high whenever `gnt` is non-zero.

## Operation
- **State machine.** Two states, IDLE and OWNED.
- **Pointer.** `ptr[1:0]` is the index of the master with highest priority in the next arbitration.
  - Priority order is `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, all mod 4.
- **Arbitration.** Rotate `req` right by `ptr`, then casez-priority-encode with the LSB highest:
  - `???1` → 0, `??10` → 1, `?100` → 2, `1000` → 3, `0000` → none.
  - Winner index = encoded + `ptr` (mod 4).
- **IDLE.**
  - If `req` is non-zero, grant the winner, enter OWNED, set `hold_cnt` = 1.
  - Otherwise stay in IDLE.
- **OWNED with `req[gnt_id]` = 1.**
  - If `hold_cnt` < `MAX_HOLD`, or no other request is pending, keep the grant. `hold_cnt` increments and saturates at `MAX_HOLD`.
  - If `hold_cnt` == `MAX_HOLD` and another request is pending, force rotation:
    - Set `ptr` = `gnt_id` + 1.
    - Arbitrate over `req` with the current owner's bit masked.
    - Grant the winner, reset `hold_cnt` to 1.
- **OWNED with `req[gnt_id]` = 0 (release).**
  - Set `ptr` = `gnt_id` + 1.
  - If any request remains, grant its winner in the same edge (zero-bubble handover) and reset `hold_cnt` to 1.
  - Otherwise go to IDLE: `gnt` = 0, `gnt_id` = 0.
- **Pointer update rule.** `ptr` changes only on release or forced rotation, never on initial grant from IDLE.
- **Width rules.**
  - `hold_cnt` width is $clog2(`MAX_HOLD`+1).
  - `ptr` and index additions wrap modulo 4, e.g. 3+1 = 0.

## Timing
- **Reset values.** `gnt` = 0000, `gnt_id` = 0, `busy` = 0, `ptr` = 0, `hold_cnt` = 0, state = IDLE.
  - Reset asserts immediately, mid-grant included.
- **Grant latency.** Request sampled at edge N → `gnt` valid after edge N (registered; visible in the cycle following the sampling edge). No combinational path from `req` to `gnt`.
- **Handover.** A release sampled at edge N yields the new grant after the same edge N. `gnt` never shows two bits set and has no idle gap when requests remain.
- **Forced rotation.** An owner that holds continuously with a competitor waiting loses the grant at the edge where it has held `MAX_HOLD` cycles.
- **Simultaneous events.**
  - Owner release and a new request in the same cycle: the new request competes under the updated `ptr`.
  - A request rising in the same cycle as reset deassertion is arbitrated at the first clock edge after reset.
- **Masters may not be re-granted early.** A master that drops and re-raises `req` while others wait is served only after the rotation reaches it.

## Structure
- **Shared package `arb_pkg`.**
  - Parameter `NREQ` = 4.
  - Typedef `req_vec_t` (logic [3:0]).
  - Typedef `idx_t` (logic [1:0]).
  - State enum `arb_state_t` {IDLE, OWNED}.
- **Sub-module `prio_enc4_casez`.**
  - Purely combinational: input 4-bit vector, outputs `idx[1:0]` and `valid`.
  - Implemented with a casez priority table.
  - Instanced once on the rotated and masked request vector.
- **Top-level logic.** Rotation, masking, pointer, counter and FSM live in `rr_arbiter4`.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-grant with `req`=0101 → `gnt`=0000, `gnt_id`=0, `busy`=0 immediately. After release with `req`=0101 → `gnt`=0001.
- **Fair rotation.** `req`=1111 held, each master drops `req` one cycle after its grant then re-raises → grant sequence 0001, 0010, 0100, 1000, 0001 with zero idle cycles.
- **Forced rotation.** `MAX_HOLD`=8, `req`=0011 held constantly → `gnt`=0001 for 8 cycles, then 0010 for 8 cycles, then 0001. `busy` stays at 1 throughout.
- **Lone holder.** `req`=0100 held for 20 cycles → `gnt`=0100 throughout, with no forced release. Then `req`=0000 → `gnt`=0000 and `busy`=0 after the next edge.
- **Wrap and simultaneous release.** `ptr`=3 state (master 2 just released) with `req`=1001 → `gnt`=1000. Then master 3 releases while `req[0]` stays high → `gnt`=0001 on the same edge.
- **Idle restart.** After all requests drop, with `ptr`=2, raise `req`=0011 → `gnt`=0001, the first requester at or after `ptr`=2 in wrap order.
